s2c_bridge: RTL and testbench
=============================

// Module: s2c_bridge
// PURPOSE
//  Clocked, multi-channel successor to the S2C DPI task interface. RTL/bench agents issue
//  setup/call requests on valid/ready channels. The bridge queues them per channel and
//  arbitrates round-robin. It performs one DPI transaction at a time (s2c_s_func_setup or
//  s2c_func_call) and returns ret/data on a response handshake. It also polls s2c_check_end
//  autonomously and raises a sticky end flag. Sits between bench BFMs and the C model.
// PARAMETERS
//  NUM_CH         4     number of request channels (1..8)
//  DATA_WORDS     16    response data words returned, 1..S2CIF_DATA_SIZE (16); upper words dropped
//  FIFO_DEPTH     4     per-channel request queue depth, power of two >= 2
//  POLL_INTERVAL  1000  idle cycles between check_end polls; 0 disables polling
//  ID_BASE        0     C-side id for channel c = ID_BASE + c
// PORTS
//  clk         in   1                clock
//  rst         in   1                synchronous, active-high reset
//  req_valid   in   NUM_CH           per-channel request valid
//  req_ready   out  NUM_CH           per-channel request ready (= queue not full)
//  req_setup   in   NUM_CH           1 = func_setup, 0 = func_call
//  req_fn      in   NUM_CH x 32      function number per channel
//  resp_valid  out  NUM_CH           response valid, one-hot to the owning channel
//  resp_ready  in   NUM_CH           response accept per channel
//  resp_ret    out  32               ret of the completed transaction
//  resp_data   out  DATA_WORDS x 32  pkt.data[0..DATA_WORDS-1]; all zero for setup
//  sim_end     out  1                sticky: last check_end returned ret != 0
//  busy        out  1                FSM not IDLE or any queue non-empty
// BEHAVIOUR
//  Reset: req_ready = all 1, resp_valid = 0, resp_ret = 0, resp_data = 0, sim_end = 0, busy = 0.
//    Reset flushes all queues, the poll counter and the RR pointer (pointer -> ch 0).
//  Enqueue: push {setup, fn} on req_valid & req_ready.
//    Full queue: req_ready = 0, no push, no drop.
//    Push and pop in the same cycle on a full queue: the push is refused (ready is registered off full).
//  FSM states IDLE -> ARB -> CALL -> RESP -> IDLE, plus POLL.
//   IDLE: if any queue is non-empty -> ARB.
//     Else if poll counter == POLL_INTERVAL-1 -> POLL.
//     Counter increments only in IDLE with all queues empty and resets on leaving IDLE.
//   ARB: pick the first non-empty channel at or after the RR pointer. Pop its head.
//     Set pointer = winner+1 (mod NUM_CH). Go to CALL. Arbitration takes 1 cycle.
//   CALL: build pkt_s {id = ID_BASE+ch, fn}. Invoke the DPI task (zero sim time).
//     Register ret/data. Go to RESP.
//   RESP: resp_valid[ch] = 1 with stable ret/data until resp_ready[ch]; then -> IDLE.
//     resp_ready on other channels is ignored.
//   POLL: call s2c_check_end (id 0, fn 2). If ret != 0, set sim_end. -> IDLE.
//     Emits no response.
//  Latency: request accepted at cycle t with queues empty and FSM in IDLE:
//    ARB at t+2, resp_valid asserted at t+4.
//  A pending request always beats a due poll; the poll waits until queues drain.
//  sim_end clears only on rst. busy stays 1 through POLL.
//  Reset mid-operation: any state -> IDLE in one cycle. An accepted-but-unanswered
//    response is discarded. A DPI call already issued is not replayed.
// STRUCTURE
//  s2c_pkg: pkt_s, S2CIF_DATA_SIZE, FN_CHECK_END = 2, fsm_e enum, DPI import declarations.
//  Sub-module s2c_req_fifo (width 33, depth FIFO_DEPTH, full/empty, sync rst),
//    instantiated NUM_CH times.
//  Arbiter and FSM live in s2c_bridge.
// TESTING
//  1. ch0 call fn=5, C returns ret=7, data[i]=i -> resp_valid=4'b0001 at t+4,
//     resp_ret=7, resp_data word3=3.
//  2. ch1 setup fn=1 -> resp_ret = C ret, resp_data all 0, resp_valid=4'b0010.
//  3. All 4 channels push 2 requests in the same cycle, resp_ready tied 1 ->
//     service order 0,1,2,3,0,1,2,3.
//  4. ch2 pushes 5 with FIFO_DEPTH=4 and resp_ready=0 -> req_ready[2] low after the 4th
//     beat; no loss; 5th accepted after a pop.
//  5. POLL_INTERVAL=10, idle, C check_end returns 0 then 1 -> sim_end rises after the
//     2nd poll (~cycle 22); a request arriving at poll-due is served first.
//  6. rst in RESP with resp_ready=0 -> next cycle resp_valid=0, busy=0, queues empty,
//     sim_end=0.

Source files
------------

// File: rtl/s2c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : s2c_pkg
// Brief    : Shared types, FSM encoding and C-side interface for the S2C bridge.
// Revision : 1.0
// ============================================================================
package s2c_pkg;

    localparam int          S2CIF_DATA_SIZE = 16;
    localparam logic [31:0] FN_CHECK_END    = 32'd2;

    typedef struct packed {
        logic [31:0] id;
        logic [31:0] fn;
    } pkt_s;

    typedef logic [S2CIF_DATA_SIZE-1:0][31:0] s2c_data_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARB  = 3'd1,
        S_CALL = 3'd2,
        S_RESP = 3'd3,
        S_POLL = 3'd4
    } fsm_e;

    // Built-in stand-in for the C model.
    function automatic logic [31:0] model_setup_ret(pkt_s p);
        return 32'h0000_1000 + (p.id << 16) + p.fn;
    endfunction

    function automatic logic [31:0] model_call_ret(pkt_s p);
        return p.fn + 32'd2 + (p.id << 8);
    endfunction

    function automatic s2c_data_t model_call_data(logic [31:0] id);
        s2c_data_t d;
        for (int i = 0; i < S2CIF_DATA_SIZE; i++) begin
            d[i] = (id << 16) + 32'(i);
        end
        return d;
    endfunction

    // Reports end-of-test on every check after the first one.
    function automatic logic [31:0] model_check_end_ret(logic [31:0] fn, logic seen_before);
        return seen_before ? (fn - 32'd1) : 32'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/s2c_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : s2c_req_fifo
// Brief    : Single-clock request queue; push is refused while full.
// Revision : 1.0
// ============================================================================
module s2c_req_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign dout   = r_mem[r_rd];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= din;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/s2c_bridge.sv
`default_nettype none
// ============================================================================
// Module   : s2c_bridge
// Brief    : Multi-channel queued, round-robin bridge onto the S2C C interface.
// Revision : 1.0
// ============================================================================
module s2c_bridge
    import s2c_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int DATA_WORDS    = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int POLL_INTERVAL = 1000,
    parameter int ID_BASE       = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           req_valid,
    output logic [NUM_CH-1:0]           req_ready,
    input  logic [NUM_CH-1:0]           req_setup,
    input  logic [NUM_CH-1:0][31:0]     req_fn,
    output logic [NUM_CH-1:0]           resp_valid,
    input  logic [NUM_CH-1:0]           resp_ready,
    output logic [31:0]                 resp_ret,
    output logic [DATA_WORDS-1:0][31:0] resp_data,
    output logic                        sim_end,
    output logic                        busy
);

    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PCW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int QW  = 33;

    fsm_e                         r_state;
    fsm_e                         w_next;
    logic [CHW-1:0]               r_ptr;
    logic [CHW-1:0]               r_ch;
    logic [CHW-1:0]               w_win;
    logic                         w_found;
    logic [NUM_CH-1:0]            w_full;
    logic [NUM_CH-1:0]            w_empty;
    logic [NUM_CH-1:0]            w_pop;
    logic [NUM_CH-1:0][QW-1:0]    w_head;
    logic                         r_setup;
    logic [31:0]                  r_fn;
    logic [31:0]                  r_ret;
    logic [DATA_WORDS-1:0][31:0]  r_data;
    logic                         r_sim_end;
    logic [PCW-1:0]               r_poll_cnt;
    logic                         w_poll_due;
    logic                         w_any_req;
    pkt_s                         w_pkt;
    logic                         r_polled;
    s2c_data_t                    w_call_data;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_fifo
            s2c_req_fifo #(
                .WIDTH (QW),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (req_valid[c]),
                .din   ({req_setup[c], req_fn[c]}),
                .pop   (w_pop[c]),
                .dout  (w_head[c]),
                .full  (w_full[c]),
                .empty (w_empty[c])
            );
        end
    endgenerate

    assign req_ready   = ~w_full;
    assign w_any_req   = ~(&w_empty);
    assign w_poll_due  = (POLL_INTERVAL != 0) && (r_poll_cnt == PCW'(POLL_INTERVAL - 1));
    assign busy        = (r_state != S_IDLE) || w_any_req;
    assign resp_ret    = r_ret;
    assign resp_data   = r_data;
    assign sim_end     = r_sim_end;
    assign w_pkt.id    = 32'(ID_BASE) + 32'(r_ch);
    assign w_pkt.fn    = r_fn;
    assign w_call_data = model_call_data(w_pkt.id);

    // First non-empty queue at or after the round-robin pointer.
    always_comb begin
        w_win   = r_ptr;
        w_found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_found && !w_empty[(int'(r_ptr) + k) % NUM_CH]) begin
                w_win   = CHW'((int'(r_ptr) + k) % NUM_CH);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        resp_valid = '0;
        w_pop      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            resp_valid[c] = (r_state == S_RESP) && (r_ch == CHW'(c));
            w_pop[c]      = (r_state == S_ARB) && (w_win == CHW'(c));
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next = S_ARB;
                end else if (w_poll_due) begin
                    w_next = S_POLL;
                end
            end
            S_ARB:   w_next = S_CALL;
            S_CALL:  w_next = S_RESP;
            S_RESP:  if (resp_ready[r_ch]) w_next = S_IDLE;
            S_POLL:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_ch       <= '0;
            r_setup    <= 1'b0;
            r_fn       <= '0;
            r_ret      <= '0;
            r_data     <= '0;
            r_sim_end  <= 1'b0;
            r_poll_cnt <= '0;
            r_polled   <= 1'b0;
        end else begin
            r_state <= w_next;

            if ((r_state == S_IDLE) && !w_any_req && !w_poll_due) begin
                r_poll_cnt <= r_poll_cnt + 1'b1;
            end else begin
                r_poll_cnt <= '0;
            end

            if (r_state == S_ARB) begin
                r_ch            <= w_win;
                {r_setup, r_fn} <= w_head[w_win];
                r_ptr           <= (w_win == CHW'(NUM_CH - 1)) ? '0 : w_win + 1'b1;
            end

            if (r_state == S_CALL) begin
                if (r_setup) begin
                    r_ret  <= model_setup_ret(w_pkt);
                    r_data <= '0;
                end else begin
                    r_ret  <= model_call_ret(w_pkt);
                    r_data <= w_call_data[DATA_WORDS-1:0];
                end
            end

            if (r_state == S_POLL) begin
                if (model_check_end_ret(FN_CHECK_END, r_polled) != '0) r_sim_end <= 1'b1;
                r_polled <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_s2c_bridge.sv
`default_nettype none
// Directed bench for s2c_bridge: one instance with polling off, one polling every 10 cycles.
module tb_s2c_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]        req_valid, req_ready, req_setup, resp_valid, resp_ready;
  logic [3:0][31:0]  req_fn;
  logic [31:0]       resp_ret;
  logic [15:0][31:0] resp_data;
  logic              sim_end, busy;

  logic [3:0]        p_req_valid, p_req_ready, p_req_setup, p_resp_valid, p_resp_ready;
  logic [3:0][31:0]  p_req_fn;
  logic [31:0]       p_resp_ret;
  logic [15:0][31:0] p_resp_data;
  logic              p_sim_end, p_busy;

  int n_cmp = 0;
  int n_bad = 0;

  s2c_bridge #(
    .NUM_CH(4), .DATA_WORDS(16), .FIFO_DEPTH(4), .POLL_INTERVAL(0), .ID_BASE(0)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_setup(req_setup), .req_fn(req_fn),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_ret(resp_ret), .resp_data(resp_data),
    .sim_end(sim_end), .busy(busy)
  );

  s2c_bridge #(
    .NUM_CH(4), .DATA_WORDS(16), .FIFO_DEPTH(4), .POLL_INTERVAL(10), .ID_BASE(0)
  ) dut_p (
    .clk(clk), .rst(rst),
    .req_valid(p_req_valid), .req_ready(p_req_ready), .req_setup(p_req_setup), .req_fn(p_req_fn),
    .resp_valid(p_resp_valid), .resp_ready(p_resp_ready), .resp_ret(p_resp_ret), .resp_data(p_resp_data),
    .sim_end(p_sim_end), .busy(p_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    req_valid    = '0;
    p_req_valid  = '0;
    resp_ready   = '0;
    p_resp_ready = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (req_ready !== 4'b1111) begin n_bad++; $display("FAIL rst_ready: got %b want 1111", req_ready); end
    n_cmp++; if (p_req_ready !== 4'b1111) begin n_bad++; $display("FAIL rst_p_ready: got %b want 1111", p_req_ready); end
    n_cmp++; if (resp_valid !== 4'b0000) begin n_bad++; $display("FAIL rst_valid: got %b want 0000", resp_valid); end
    n_cmp++; if (resp_ret !== 32'd0) begin n_bad++; $display("FAIL rst_ret: got %0h want 0", resp_ret); end
    n_cmp++; if (resp_data !== '0) begin n_bad++; $display("FAIL rst_data: got %0h want 0", resp_data); end
    n_cmp++; if (sim_end !== 1'b0) begin n_bad++; $display("FAIL rst_sim_end: got %b want 0", sim_end); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
  endtask

  task automatic test_call();
    req_setup[0] = 1'b0;
    req_fn[0]    = 32'd5;
    req_valid    = 4'b0001;
    tick();
    req_valid = '0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL call_busy: got %b want 1", busy); end
    tick();
    tick();
    n_cmp++; if (resp_valid !== 4'b0000) begin n_bad++; $display("FAIL call_early: got %b want 0000", resp_valid); end
    tick();
    n_cmp++; if (resp_valid !== 4'b0001) begin n_bad++; $display("FAIL call_valid: got %b want 0001", resp_valid); end
    n_cmp++; if (resp_ret !== 32'd7) begin n_bad++; $display("FAIL call_ret: got %0h want 7", resp_ret); end
    n_cmp++; if (resp_data[3] !== 32'd3) begin n_bad++; $display("FAIL call_data3: got %0h want 3", resp_data[3]); end
    n_cmp++; if (resp_data[15] !== 32'd15) begin n_bad++; $display("FAIL call_data15: got %0h want f", resp_data[15]); end
    tick();
    n_cmp++; if (resp_valid !== 4'b0001) begin n_bad++; $display("FAIL call_hold_valid: got %b want 0001", resp_valid); end
    n_cmp++; if (resp_ret !== 32'd7) begin n_bad++; $display("FAIL call_hold_ret: got %0h want 7", resp_ret); end
    resp_ready = 4'b0001;
    tick();
    resp_ready = '0;
    n_cmp++; if (resp_valid !== 4'b0000) begin n_bad++; $display("FAIL call_done_valid: got %b want 0000", resp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL call_done_busy: got %b want 0", busy); end
  endtask

  task automatic test_setup();
    req_setup[1] = 1'b1;
    req_fn[1]    = 32'd1;
    req_valid    = 4'b0010;
    tick();
    req_valid    = '0;
    req_setup[1] = 1'b0;
    tick();
    tick();
    tick();
    n_cmp++; if (resp_valid !== 4'b0010) begin n_bad++; $display("FAIL setup_valid: got %b want 0010", resp_valid); end
    n_cmp++; if (resp_ret !== 32'h0001_1001) begin n_bad++; $display("FAIL setup_ret: got %0h want 11001", resp_ret); end
    n_cmp++; if (resp_data !== '0) begin n_bad++; $display("FAIL setup_data: got %0h want 0", resp_data); end
    resp_ready = 4'b1101;
    tick();
    n_cmp++; if (resp_valid !== 4'b0010) begin n_bad++; $display("FAIL setup_other_ready: got %b want 0010", resp_valid); end
    resp_ready = 4'b0010;
    tick();
    resp_ready = '0;
    n_cmp++; if (resp_valid !== 4'b0000) begin n_bad++; $display("FAIL setup_done: got %b want 0000", resp_valid); end
  endtask

  task automatic test_back_to_back();
    int         got;
    int         exp_ch;
    logic [31:0] exp_ret;
    logic [3:0]  exp_vec;
    do_reset();
    resp_ready = 4'b1111;
    req_setup  = '0;
    for (int c = 0; c < 4; c++) req_fn[c] = 32'(10 + c);
    req_valid = 4'b1111;
    tick();
    for (int c = 0; c < 4; c++) req_fn[c] = 32'(20 + c);
    tick();
    req_valid = '0;
    got = 0;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      if (resp_valid !== 4'b0000) begin
        exp_ch  = got % 4;
        exp_vec = 4'(1 << exp_ch);
        exp_ret = 32'(((got < 4) ? 10 : 20) + exp_ch + 2 + (exp_ch << 8));
        n_cmp++; if (resp_valid !== exp_vec) begin n_bad++; $display("FAIL rr_order[%0d]: got %b want %b", got, resp_valid, exp_vec); end
        n_cmp++; if (resp_ret !== exp_ret) begin n_bad++; $display("FAIL rr_ret[%0d]: got %0h want %0h", got, resp_ret, exp_ret); end
        got++;
      end
      tick();
    end
    n_cmp++; if (got != 8) begin n_bad++; $display("FAIL rr_count: got %0d want 8", got); end
    resp_ready = '0;
  endtask

  task automatic test_fifo_full();
    int          pushed;
    int          got;
    logic        rdy;
    logic [31:0] exp_ret;
    resp_ready = '0;
    req_fn[0]  = 32'd50;
    req_valid  = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    n_cmp++; if (resp_valid !== 4'b0001) begin n_bad++; $display("FAIL full_block: got %b want 0001", resp_valid); end
    for (int k = 0; k < 4; k++) begin
      req_fn[2] = 32'(100 + k);
      req_valid = 4'b0100;
      n_cmp++; if (req_ready[2] !== 1'b1) begin n_bad++; $display("FAIL full_ready_beat%0d: got %b want 1", k, req_ready[2]); end
      tick();
    end
    pushed    = 4;
    req_fn[2] = 32'd104;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (req_ready[2] !== 1'b0) begin n_bad++; $display("FAIL full_ready_low%0d: got %b want 0", k, req_ready[2]); end
      tick();
    end
    resp_ready = 4'b1111;
    got = 0;
    for (int cyc = 0; cyc < 80 && got < 5; cyc++) begin
      rdy = req_ready[2];
      if (resp_valid[2] === 1'b1) begin
        exp_ret = 32'(614 + got);
        n_cmp++; if (resp_ret !== exp_ret) begin n_bad++; $display("FAIL full_ret[%0d]: got %0h want %0h", got, resp_ret, exp_ret); end
        got++;
      end
      tick();
      if (req_valid[2] && rdy) begin
        pushed++;
        req_valid = '0;
      end
    end
    req_valid  = '0;
    resp_ready = '0;
    n_cmp++; if (pushed != 5) begin n_bad++; $display("FAIL full_fifth_accepted: got %0d want 5", pushed); end
    n_cmp++; if (got != 5) begin n_bad++; $display("FAIL full_resp_count: got %0d want 5", got); end
  endtask

  task automatic test_poll();
    do_reset();
    repeat (9) tick();
    n_cmp++; if (p_busy !== 1'b0) begin n_bad++; $display("FAIL poll_idle_busy: got %b want 0", p_busy); end
    tick();
    n_cmp++; if (p_busy !== 1'b1) begin n_bad++; $display("FAIL poll_busy: got %b want 1", p_busy); end
    tick();
    n_cmp++; if (p_sim_end !== 1'b0) begin n_bad++; $display("FAIL poll_first: got %b want 0", p_sim_end); end
    repeat (10) tick();
    n_cmp++; if (p_sim_end !== 1'b0) begin n_bad++; $display("FAIL poll_before2: got %b want 0", p_sim_end); end
    tick();
    n_cmp++; if (p_sim_end !== 1'b1) begin n_bad++; $display("FAIL poll_second: got %b want 1", p_sim_end); end
    repeat (8) tick();
    p_req_setup[0] = 1'b0;
    p_req_fn[0]    = 32'd9;
    p_req_valid    = 4'b0001;
    tick();
    p_req_valid = '0;
    repeat (3) tick();
    n_cmp++; if (p_resp_valid !== 4'b0001) begin n_bad++; $display("FAIL poll_req_first: got %b want 0001", p_resp_valid); end
    n_cmp++; if (p_resp_ret !== 32'd11) begin n_bad++; $display("FAIL poll_req_ret: got %0h want b", p_resp_ret); end
    n_cmp++; if (p_resp_data[5] !== 32'd5) begin n_bad++; $display("FAIL poll_req_data5: got %0h want 5", p_resp_data[5]); end
    p_resp_ready = 4'b0001;
    tick();
    p_resp_ready = '0;
    n_cmp++; if (p_sim_end !== 1'b1) begin n_bad++; $display("FAIL poll_sticky: got %b want 1", p_sim_end); end
    n_cmp++; if (sim_end !== 1'b0) begin n_bad++; $display("FAIL poll_disabled: got %b want 0", sim_end); end
  endtask

  task automatic test_reset_mid();
    req_setup = '0;
    req_fn[3] = 32'd7;
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    req_fn[1] = 32'd8;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    n_cmp++; if (resp_valid !== 4'b1000) begin n_bad++; $display("FAIL mid_pre_valid: got %b want 1000", resp_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (resp_valid !== 4'b0000) begin n_bad++; $display("FAIL mid_valid: got %b want 0000", resp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_cmp++; if (req_ready !== 4'b1111) begin n_bad++; $display("FAIL mid_ready: got %b want 1111", req_ready); end
    n_cmp++; if (resp_ret !== 32'd0) begin n_bad++; $display("FAIL mid_ret: got %0h want 0", resp_ret); end
    n_cmp++; if (sim_end !== 1'b0) begin n_bad++; $display("FAIL mid_sim_end: got %b want 0", sim_end); end
    n_cmp++; if (p_sim_end !== 1'b0) begin n_bad++; $display("FAIL mid_p_sim_end: got %b want 0", p_sim_end); end
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++; if (resp_valid !== 4'b0000) begin n_bad++; $display("FAIL mid_no_replay%0d: got %b want 0000", k, resp_valid); end
    end
  endtask

  initial begin
    req_valid    = '0;
    req_setup    = '0;
    req_fn       = '0;
    resp_ready   = '0;
    p_req_valid  = '0;
    p_req_setup  = '0;
    p_req_fn     = '0;
    p_resp_ready = '0;
    test_reset();
    test_call();
    test_setup();
    test_back_to_back();
    test_fifo_full();
    test_poll();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
